argmax_tree: RTL and testbench
==============================

# argmax_tree

Parametrised, pipelined argmax reducer with a valid/ready handshake. It takes one vector of NUM_CLASSES scores per transfer and returns the index and value of the maximum. Optionally it also returns the confidence margin between the top score and the runner-up. It sits after the final classifier layer and generalises the fixed 29-class, 8-bit, no-backpressure winner tree to any class count, data width and signedness.

## Interface
- NUM_CLASSES, 29: number of scores per vector; legal range 2..1024.
- DATA_W, 8: score width in bits.
- SIGNED, 0: 0 treats scores as unsigned, 1 as two's complement.
- IDX_W, $clog2(NUM_CLASSES): index width (derived; do not override).
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_data  in  NUM_CLASSES*DATA_W  packed scores; class i occupies bits [i*DATA_W +: DATA_W].
- in_valid  in  1  input vector valid.
- in_ready  out  1  block can accept a vector.
- out_idx  out  IDX_W  index of the winning class.
- out_data  out  DATA_W  winning score.
- out_margin  out  DATA_W  unsigned (top1 − top2); 0 when ARGMAX_MARGIN_EN is undefined.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.

## Operation
- Radix-4 comparison tree with STAGES = ceil(log4(NUM_CLASSES)) register stages; for 29 classes, STAGES = 3.
- Each node compares up to 4 (value, index) pairs and registers the winner.
- Node input counts:
  - stage 0 nodes take 4 classes each; the last node takes the remainder;
  - later stages take 4 previous winners each.
- Missing node inputs are padded:
  - value = type minimum (0 unsigned, −2^(DATA_W−1) signed);
  - index = all ones.
- Tie-break: on equal values the lower index wins, at every node. The overall result is therefore the lowest index among equal maxima, and padding never displaces a real class.
- Comparison honours SIGNED throughout.
- Margin mode: each node also carries the runner-up value.
  - Node runner-up = max of: the losing inputs' top values, and the winning input's runner-up.
  - Stage-0 inputs carry runner-up = type minimum.
  - out_margin = top − runner-up, computed in DATA_W+1 bits and truncated to DATA_W (the difference always fits).
  - Equal maxima give margin 0.
- Handshake:
  - An input transfer occurs when in_valid & in_ready.
  - An output transfer occurs when out_valid & out_ready.
  - Per-stage valid bits; stage k loads when stage k is empty or stage k+1 loads (the output stage loads when empty or out_ready). Bubbles collapse.
  - in_ready = stage-0 load enable.
  - Results leave in input order and are never dropped or duplicated.
- out_idx/out_data/out_margin hold stable while out_valid & ~out_ready.

## Timing
- Latency: an accepted input appears at out_valid exactly STAGES cycles later (3 for 29 classes) when out_ready stays high.
- Throughput: 1 vector/cycle with out_ready high.
- Pipeline capacity: STAGES vectors.
- in_ready is combinational from out_ready and the stage valids. No combinational path exists from in_data/in_valid to any output.
- Full pipeline with out_ready low: in_ready = 0 in that cycle.
- Full pipeline with out_ready high: in_ready = 1 in that cycle; a simultaneous input and output transfer is legal.
- Reset values: out_valid 0, out_idx 0, out_data 0, out_margin 0, all stage valids 0. in_ready = 1 one cycle after reset deasserts.
- Reset asserted mid-operation: all in-flight vectors are discarded immediately, and out_valid falls asynchronously.

## Configuration
- ARGMAX_MARGIN_EN defined: runner-up tracking and the margin datapath are built; out_margin is live.
- ARGMAX_MARGIN_EN undefined: no runner-up logic is synthesised; out_margin is tied to 0. Index, value, latency and handshake are identical in both builds.

## Test plan
- Basic (29 classes, 8-bit unsigned): all scores 10, class 17 = 200, out_ready = 1 -> 3 cycles later out_valid = 1, out_idx 17, out_data 200, out_margin 190 (0 without the macro).
- Tie: classes 5 and 22 = 255, others 0 -> out_idx 5, out_data 255, out_margin 0.
- Signed (SIGNED=1): all −128 except class 28 = −1 and class 3 = −100 -> out_idx 28, out_data 0xFF, out_margin 99.
- Backpressure: stream 6 vectors back-to-back, out_ready low for cycles 2..7 -> in_ready drops after 3 vectors are held; all 6 results emerge in order; outputs are stable while stalled.
- Throughput: 100 random vectors with out_ready = 1 -> one result per cycle, each matching the reference argmax (lowest index on ties).
- Reset mid-stream: assert reset with 2 vectors in flight -> out_valid = 0 at once; after release, no stale results appear and the next vector returns after 3 cycles.

Source files
------------

// File: rtl/argmax_tree_if.sv
// Score-vector in / winner out bus for argmax_tree.
//
// Handshake: a transfer happens on a rising clk edge where valid and ready
// are both high. A producer holds its payload and valid steady until that
// edge; ready may depend combinationally on the consumer's own state and on
// out_ready, but never on the matching valid or payload.
interface argmax_tree_if #(
  parameter int NUM_CLASSES = 29,
  parameter int DATA_W      = 8,
  parameter int IDX_W       = $clog2(NUM_CLASSES)
);
  logic [NUM_CLASSES*DATA_W-1:0] in_data;
  logic                          in_valid;
  logic                          in_ready;
  logic [IDX_W-1:0]              out_idx;
  logic [DATA_W-1:0]             out_data;
  logic [DATA_W-1:0]             out_margin;
  logic                          out_valid;
  logic                          out_ready;

  // Side that supplies vectors and consumes results.
  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_idx, out_data, out_margin, out_valid
  );

  // The reducer itself.
  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_idx, out_data, out_margin, out_valid
  );
endinterface

// File: rtl/argmax_tree.sv
// Pipelined radix-4 argmax reducer with valid/ready flow control.
// Each register stage folds groups of four (value, index) pairs into one
// winner; the lower index wins on equal values so the final answer is the
// lowest index among equal maxima. Empty node inputs are padded with the type
// minimum and an all-ones index so they never displace a real class.
// Optional build macro ARGMAX_MARGIN_EN: carries a runner-up value through
// the tree and drives out_margin = top - runner-up; without it out_margin is 0
// and no runner-up logic exists.
module argmax_tree #(
  parameter int NUM_CLASSES = 29,
  parameter int DATA_W      = 8,
  parameter bit SIGNED      = 1'b0,
  parameter int IDX_W       = $clog2(NUM_CLASSES)
) (
  input logic          clk,
  input logic          reset,
  argmax_tree_if.slave bus
);

  // Number of radix-4 levels needed to reduce n entries to one.
  function automatic int calc_stages(input int n);
    int s;
    int r;
    s = 0;
    r = n;
    while (r > 1) begin
      r = (r + 3) / 4;
      s++;
    end
    return s;
  endfunction

  // Entry count feeding level k (level 0 is the raw class vector).
  function automatic int level_n(input int k);
    int r;
    r = NUM_CLASSES;
    for (int s = 0; s < k; s++) r = (r + 3) / 4;
    return r;
  endfunction

  localparam int STAGES = calc_stages(NUM_CLASSES);

  // Type minimum: only the sign bit set for two's complement, zero otherwise.
  localparam logic [DATA_W-1:0] V_MIN = {SIGNED, {(DATA_W-1){1'b0}}};

  // Flipping the sign bit turns a signed ordering into an unsigned one.
  function automatic logic [DATA_W-1:0] order_key(input logic [DATA_W-1:0] v);
    return v ^ V_MIN;
  endfunction

  // True when candidate a should replace b as the winner.
  function automatic logic beats(input logic [DATA_W-1:0] v_a, input logic [IDX_W-1:0] i_a,
                                 input logic [DATA_W-1:0] v_b, input logic [IDX_W-1:0] i_b);
    return (order_key(v_a) > order_key(v_b)) || ((v_a == v_b) && (i_a < i_b));
  endfunction

`ifdef ARGMAX_MARGIN_EN
  function automatic logic [DATA_W-1:0] vmax(input logic [DATA_W-1:0] a,
                                             input logic [DATA_W-1:0] b);
    return (order_key(a) >= order_key(b)) ? a : b;
  endfunction
`endif

  logic [STAGES-1:0] stg_vld;
  logic [STAGES-1:0] stg_load;

  // A stage loads when empty or when its successor drains it; the last stage
  // drains into out_ready. This collapses bubbles and makes in_ready a pure
  // function of the stage valids and out_ready.
  always_comb begin
    logic ld;
    stg_load = '0;
    ld = ~stg_vld[STAGES-1] | bus.out_ready;
    stg_load[STAGES-1] = ld;
    for (int k = STAGES - 2; k >= 0; k--) begin
      ld = ~stg_vld[k] | ld;
      stg_load[k] = ld;
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int IN_N  = level_n(k);
    localparam int OUT_N = level_n(k + 1);

    logic [IN_N*DATA_W-1:0]  in_v;
    logic [IN_N*IDX_W-1:0]   in_i;
    logic                    in_vld;
    logic [OUT_N*DATA_W-1:0] d_v;
    logic [OUT_N*IDX_W-1:0]  d_i;
    logic [OUT_N*DATA_W-1:0] q_v;
    logic [OUT_N*IDX_W-1:0]  q_i;
    logic                    vld;
`ifdef ARGMAX_MARGIN_EN
    logic [IN_N*DATA_W-1:0]  in_r;
    logic [OUT_N*DATA_W-1:0] d_r;
    logic [OUT_N*DATA_W-1:0] q_r;
`endif

    if (k == 0) begin : g_src
      assign in_vld = bus.in_valid;
      assign in_v   = bus.in_data;
      for (genvar c = 0; c < IN_N; c++) begin : g_cls
        assign in_i[c*IDX_W +: IDX_W] = IDX_W'(c);
`ifdef ARGMAX_MARGIN_EN
        assign in_r[c*DATA_W +: DATA_W] = V_MIN;
`endif
      end
    end else begin : g_src
      assign in_vld = g_stage[k-1].vld;
      assign in_v   = g_stage[k-1].q_v;
      assign in_i   = g_stage[k-1].q_i;
`ifdef ARGMAX_MARGIN_EN
      assign in_r   = g_stage[k-1].q_r;
`endif
    end

    for (genvar j = 0; j < OUT_N; j++) begin : g_node
      logic [4*DATA_W-1:0] c_v;
      logic [4*IDX_W-1:0]  c_i;
      logic [DATA_W-1:0]   w_v;
      logic [IDX_W-1:0]    w_i;
`ifdef ARGMAX_MARGIN_EN
      logic [4*DATA_W-1:0] c_r;
      logic [DATA_W-1:0]   w_r;
`endif

      for (genvar m = 0; m < 4; m++) begin : g_in
        if (4 * j + m < IN_N) begin : g_real
          assign c_v[m*DATA_W +: DATA_W] = in_v[(4*j+m)*DATA_W +: DATA_W];
          assign c_i[m*IDX_W +: IDX_W]   = in_i[(4*j+m)*IDX_W +: IDX_W];
`ifdef ARGMAX_MARGIN_EN
          assign c_r[m*DATA_W +: DATA_W] = in_r[(4*j+m)*DATA_W +: DATA_W];
`endif
        end else begin : g_pad
          assign c_v[m*DATA_W +: DATA_W] = V_MIN;
          assign c_i[m*IDX_W +: IDX_W]   = '1;
`ifdef ARGMAX_MARGIN_EN
          assign c_r[m*DATA_W +: DATA_W] = V_MIN;
`endif
        end
      end

      // Scan the four candidates in index order; a displaced winner becomes a
      // runner-up candidate, a loser's top value competes for runner-up.
      always_comb begin
        w_v = c_v[0 +: DATA_W];
        w_i = c_i[0 +: IDX_W];
`ifdef ARGMAX_MARGIN_EN
        w_r = c_r[0 +: DATA_W];
`endif
        for (int m = 1; m < 4; m++) begin
          if (beats(c_v[m*DATA_W +: DATA_W], c_i[m*IDX_W +: IDX_W], w_v, w_i)) begin
`ifdef ARGMAX_MARGIN_EN
            w_r = vmax(w_v, c_r[m*DATA_W +: DATA_W]);
`endif
            w_v = c_v[m*DATA_W +: DATA_W];
            w_i = c_i[m*IDX_W +: IDX_W];
          end else begin
`ifdef ARGMAX_MARGIN_EN
            w_r = vmax(w_r, c_v[m*DATA_W +: DATA_W]);
`endif
          end
        end
      end

      assign d_v[j*DATA_W +: DATA_W] = w_v;
      assign d_i[j*IDX_W +: IDX_W]   = w_i;
`ifdef ARGMAX_MARGIN_EN
      assign d_r[j*DATA_W +: DATA_W] = w_r;
`endif
    end

    // Stage register: captures node winners and the upstream valid on load,
    // otherwise holds (which is what keeps the outputs stable under stall).
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        vld <= 1'b0;
        q_v <= '0;
        q_i <= '0;
`ifdef ARGMAX_MARGIN_EN
        q_r <= '0;
`endif
      end else if (stg_load[k]) begin
        vld <= in_vld;
        q_v <= d_v;
        q_i <= d_i;
`ifdef ARGMAX_MARGIN_EN
        q_r <= d_r;
`endif
      end
    end

    assign stg_vld[k] = vld;
  end

  assign bus.in_ready  = stg_load[0];
  assign bus.out_valid = stg_vld[STAGES-1];
  assign bus.out_data  = g_stage[STAGES-1].q_v;
  assign bus.out_idx   = g_stage[STAGES-1].q_i;

`ifdef ARGMAX_MARGIN_EN
  // Top never orders below the runner-up, so the modular DATA_W-bit
  // difference equals the exact non-negative margin.
  assign bus.out_margin = g_stage[STAGES-1].q_v - g_stage[STAGES-1].q_r;
`else
  assign bus.out_margin = '0;
`endif

endmodule

// File: tb/tb_argmax_tree.sv
// Directed bench for argmax_tree: 29 classes, 8-bit, one unsigned and one
// signed instance. Expected margins follow ARGMAX_MARGIN_EN.
module tb_argmax_tree;
  localparam int NC = 29;
  localparam int DW = 8;
  localparam int VW = NC * DW;
  localparam int RW = 5 + 8 + 8;

`ifdef ARGMAX_MARGIN_EN
  localparam bit MARGIN_ON = 1'b1;
`else
  localparam bit MARGIN_ON = 1'b0;
`endif

  localparam int BP_CLS  [6] = '{0, 28, 13, 7, 21, 3};
  localparam int BP_WIN  [6] = '{1, 255, 128, 64, 200, 9};
  localparam int BP_FILL [6] = '{0, 5, 7, 2, 100, 3};

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_err = 0;
  logic [RW-1:0] exp_q[$];

  argmax_tree_if #(.NUM_CLASSES(NC), .DATA_W(DW)) u_bus ();
  argmax_tree_if #(.NUM_CLASSES(NC), .DATA_W(DW)) s_bus ();

  argmax_tree #(.NUM_CLASSES(NC), .DATA_W(DW), .SIGNED(1'b0)) u_dut (
    .clk(clk), .reset(reset), .bus(u_bus)
  );
  argmax_tree #(.NUM_CLASSES(NC), .DATA_W(DW), .SIGNED(1'b1)) s_dut (
    .clk(clk), .reset(reset), .bus(s_bus)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish by 100000 time units");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Flat reference: first maximum wins, runner-up is the best of the rest.
  function automatic logic [RW-1:0] ref_argmax(input logic [VW-1:0] vec);
    int best;
    logic [7:0] bv;
    logic [7:0] sv;
    best = 0;
    bv = vec[7:0];
    for (int i = 1; i < NC; i++) if (vec[i*8 +: 8] > bv) begin best = i; bv = vec[i*8 +: 8]; end
    sv = 8'd0;
    for (int i = 0; i < NC; i++) if (i != best && vec[i*8 +: 8] > sv) sv = vec[i*8 +: 8];
    return {5'(best), bv, MARGIN_ON ? 8'(bv - sv) : 8'd0};
  endfunction

  function automatic logic [VW-1:0] bp_vec(input int s);
    logic [VW-1:0] v;
    for (int c = 0; c < NC; c++) v[c*8 +: 8] = 8'(BP_FILL[s]);
    v[BP_CLS[s]*8 +: 8] = 8'(BP_WIN[s]);
    return v;
  endfunction

  function automatic logic [RW-1:0] bp_exp(input int s);
    return {5'(BP_CLS[s]), 8'(BP_WIN[s]), MARGIN_ON ? 8'(BP_WIN[s] - BP_FILL[s]) : 8'd0};
  endfunction

  // Driver: offer one vector on the unsigned bus, return latency and result.
  task automatic send_unsigned(input logic [VW-1:0] vec, output int lat, output logic [RW-1:0] res);
    int guard;
    u_bus.in_data   = vec;
    u_bus.in_valid  = 1'b1;
    u_bus.out_ready = 1'b1;
    #1;
    guard = 0;
    while (!u_bus.in_ready && guard < 20) begin tick(); guard++; end
    tick();
    u_bus.in_valid = 1'b0;
    lat = 1;
    while (!u_bus.out_valid && lat < 20) begin tick(); lat++; end
    res = {u_bus.out_idx, u_bus.out_data, u_bus.out_margin};
  endtask

  task automatic test_reset();
    reset = 1'b1;
    u_bus.in_valid = 1'b0; u_bus.in_data = '0; u_bus.out_ready = 1'b1;
    s_bus.in_valid = 1'b0; s_bus.in_data = '0; s_bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (u_bus.out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid: got %b expected 0", u_bus.out_valid); end
    n_cmp++; if (u_bus.out_idx !== 5'd0) begin n_err++; $display("FAIL rst_out_idx: got %0d expected 0", u_bus.out_idx); end
    n_cmp++; if (u_bus.out_data !== 8'd0) begin n_err++; $display("FAIL rst_out_data: got %0d expected 0", u_bus.out_data); end
    n_cmp++; if (u_bus.out_margin !== 8'd0) begin n_err++; $display("FAIL rst_out_margin: got %0d expected 0", u_bus.out_margin); end
    n_cmp++; if (s_bus.out_valid !== 1'b0) begin n_err++; $display("FAIL rst_s_out_valid: got %b expected 0", s_bus.out_valid); end
    #2 reset = 1'b0;
    tick();
    n_cmp++; if (u_bus.in_ready !== 1'b1) begin n_err++; $display("FAIL rst_in_ready: got %b expected 1", u_bus.in_ready); end
    n_cmp++; if (u_bus.out_valid !== 1'b0) begin n_err++; $display("FAIL rst_idle_valid: got %b expected 0", u_bus.out_valid); end
  endtask

  task automatic test_basic();
    logic [VW-1:0] v;
    logic [RW-1:0] res;
    int lat;
    for (int c = 0; c < NC; c++) v[c*8 +: 8] = 8'd10;
    v[17*8 +: 8] = 8'd200;
    send_unsigned(v, lat, res);
    n_cmp++; if (lat !== 3) begin n_err++; $display("FAIL basic_latency: got %0d expected 3", lat); end
    n_cmp++; if (res[20:16] !== 5'd17) begin n_err++; $display("FAIL basic_idx: got %0d expected 17", res[20:16]); end
    n_cmp++; if (res[15:8] !== 8'd200) begin n_err++; $display("FAIL basic_data: got %0d expected 200", res[15:8]); end
    n_cmp++; if (res[7:0] !== (MARGIN_ON ? 8'd190 : 8'd0)) begin n_err++; $display("FAIL basic_margin: got %0d expected %0d", res[7:0], MARGIN_ON ? 190 : 0); end
    tick();
    n_cmp++; if (u_bus.out_valid !== 1'b0) begin n_err++; $display("FAIL basic_no_dup: got %b expected 0", u_bus.out_valid); end
  endtask

  task automatic test_tie();
    logic [VW-1:0] v;
    logic [RW-1:0] res;
    int lat;
    v = '0;
    v[5*8 +: 8]  = 8'd255;
    v[22*8 +: 8] = 8'd255;
    send_unsigned(v, lat, res);
    n_cmp++; if (lat !== 3) begin n_err++; $display("FAIL tie_latency: got %0d expected 3", lat); end
    n_cmp++; if (res[20:16] !== 5'd5) begin n_err++; $display("FAIL tie_idx: got %0d expected 5", res[20:16]); end
    n_cmp++; if (res[15:8] !== 8'd255) begin n_err++; $display("FAIL tie_data: got %0d expected 255", res[15:8]); end
    n_cmp++; if (res[7:0] !== 8'd0) begin n_err++; $display("FAIL tie_margin: got %0d expected 0", res[7:0]); end
    tick();
  endtask

  task automatic test_signed();
    logic [VW-1:0] v;
    int lat;
    for (int c = 0; c < NC; c++) v[c*8 +: 8] = 8'h80;
    v[28*8 +: 8] = 8'hFF;
    v[3*8 +: 8]  = 8'h9C;
    s_bus.in_data = v; s_bus.in_valid = 1'b1; s_bus.out_ready = 1'b1;
    #1;
    n_cmp++; if (s_bus.in_ready !== 1'b1) begin n_err++; $display("FAIL signed_in_ready: got %b expected 1", s_bus.in_ready); end
    tick();
    s_bus.in_valid = 1'b0;
    lat = 1;
    while (!s_bus.out_valid && lat < 20) begin tick(); lat++; end
    n_cmp++; if (lat !== 3) begin n_err++; $display("FAIL signed_latency: got %0d expected 3", lat); end
    n_cmp++; if (s_bus.out_idx !== 5'd28) begin n_err++; $display("FAIL signed_idx: got %0d expected 28", s_bus.out_idx); end
    n_cmp++; if (s_bus.out_data !== 8'hFF) begin n_err++; $display("FAIL signed_data: got %h expected ff", s_bus.out_data); end
    n_cmp++; if (s_bus.out_margin !== (MARGIN_ON ? 8'd99 : 8'd0)) begin n_err++; $display("FAIL signed_margin: got %0d expected %0d", s_bus.out_margin, MARGIN_ON ? 99 : 0); end
    tick();
  endtask

  task automatic test_backpressure();
    int sent, got, cyc, full_seen;
    bit prev_stall;
    logic [RW-1:0] snap, obs, exp;
    sent = 0; got = 0; cyc = 0; full_seen = 0; prev_stall = 1'b0; snap = '0;
    exp_q.delete();
    while (got < 6 && cyc < 60) begin
      u_bus.out_ready = !(cyc >= 2 && cyc <= 7);
      if (sent < 6) begin u_bus.in_valid = 1'b1; u_bus.in_data = bp_vec(sent); end
      else u_bus.in_valid = 1'b0;
      #1;
      obs = {u_bus.out_idx, u_bus.out_data, u_bus.out_margin};
      if (prev_stall) begin
        n_cmp++;
        if (u_bus.out_valid !== 1'b1 || obs !== snap) begin
          n_err++; $display("FAIL bp_hold cyc %0d: got valid %b res %h expected valid 1 res %h", cyc, u_bus.out_valid, obs, snap);
        end
      end
      if (u_bus.in_valid && !u_bus.in_ready) begin
        full_seen++;
        n_cmp++; if (sent - got !== 3) begin n_err++; $display("FAIL bp_depth cyc %0d: got %0d held expected 3", cyc, sent - got); end
      end
      if (u_bus.out_valid && u_bus.out_ready) begin
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
        n_cmp++; if (obs !== exp) begin n_err++; $display("FAIL bp_result %0d: got %h expected %h", got, obs, exp); end
        got++;
      end
      prev_stall = u_bus.out_valid && !u_bus.out_ready;
      snap = obs;
      if (u_bus.in_valid && u_bus.in_ready) begin exp_q.push_back(bp_exp(sent)); sent++; end
      tick();
      cyc++;
    end
    u_bus.in_valid = 1'b0; u_bus.out_ready = 1'b1;
    n_cmp++; if (got !== 6) begin n_err++; $display("FAIL bp_count: got %0d expected 6", got); end
    n_cmp++; if (full_seen == 0) begin n_err++; $display("FAIL bp_in_ready_drop: got 0 stalled cycles expected >0"); end
    n_cmp++; if (exp_q.size() !== 0) begin n_err++; $display("FAIL bp_leftover: got %0d expected 0", exp_q.size()); end
  endtask

  task automatic test_throughput();
    int sent, got, cyc, gaps, not_ready;
    bit started;
    logic [VW-1:0] cur;
    logic [RW-1:0] obs, exp;
    sent = 0; got = 0; cyc = 0; gaps = 0; not_ready = 0; started = 1'b0;
    exp_q.delete();
    for (int c = 0; c < NC; c++) cur[c*8 +: 8] = 8'($urandom_range(0, 255));
    while (got < 100 && cyc < 300) begin
      u_bus.out_ready = 1'b1;
      u_bus.in_valid  = (sent < 100);
      u_bus.in_data   = cur;
      #1;
      if (u_bus.in_valid && !u_bus.in_ready) not_ready++;
      if (u_bus.out_valid) begin
        obs = {u_bus.out_idx, u_bus.out_data, u_bus.out_margin};
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
        n_cmp++; if (obs !== exp) begin n_err++; $display("FAIL tp_result %0d: got %h expected %h", got, obs, exp); end
        got++;
        started = 1'b1;
      end else if (started) gaps++;
      if (u_bus.in_valid && u_bus.in_ready) begin
        exp_q.push_back(ref_argmax(cur));
        sent++;
        for (int c = 0; c < NC; c++)
          cur[c*8 +: 8] = (sent % 2 == 1) ? 8'($urandom_range(0, 3)) : 8'($urandom_range(0, 255));
      end
      tick();
      cyc++;
    end
    u_bus.in_valid = 1'b0;
    n_cmp++; if (got !== 100) begin n_err++; $display("FAIL tp_count: got %0d expected 100", got); end
    n_cmp++; if (gaps !== 0) begin n_err++; $display("FAIL tp_gaps: got %0d expected 0", gaps); end
    n_cmp++; if (not_ready !== 0) begin n_err++; $display("FAIL tp_in_ready: got %0d stalls expected 0", not_ready); end
  endtask

  task automatic test_reset_mid();
    logic [VW-1:0] va, vb, vc;
    logic [RW-1:0] res;
    int lat, stale;
    for (int c = 0; c < NC; c++) begin va[c*8 +: 8] = 8'd1; vb[c*8 +: 8] = 8'd2; vc[c*8 +: 8] = 8'd3; end
    va[2*8 +: 8] = 8'd77; vb[9*8 +: 8] = 8'd88; vc[26*8 +: 8] = 8'd99;
    u_bus.out_ready = 1'b0;
    u_bus.in_data = va; u_bus.in_valid = 1'b1;
    tick();
    u_bus.in_data = vb;
    tick();
    u_bus.in_valid = 1'b0;
    tick();
    n_cmp++; if (u_bus.out_valid !== 1'b1) begin n_err++; $display("FAIL rm_pre_valid: got %b expected 1", u_bus.out_valid); end
    #2 reset = 1'b1;
    #1;
    n_cmp++; if (u_bus.out_valid !== 1'b0) begin n_err++; $display("FAIL rm_async_valid: got %b expected 0", u_bus.out_valid); end
    n_cmp++; if (u_bus.out_data !== 8'd0) begin n_err++; $display("FAIL rm_async_data: got %0d expected 0", u_bus.out_data); end
    #2 reset = 1'b0;
    tick();
    u_bus.out_ready = 1'b1;
    #1;
    n_cmp++; if (u_bus.in_ready !== 1'b1) begin n_err++; $display("FAIL rm_in_ready: got %b expected 1", u_bus.in_ready); end
    stale = 0;
    repeat (6) begin tick(); if (u_bus.out_valid) stale++; end
    n_cmp++; if (stale !== 0) begin n_err++; $display("FAIL rm_stale: got %0d results expected 0", stale); end
    send_unsigned(vc, lat, res);
    n_cmp++; if (lat !== 3) begin n_err++; $display("FAIL rm_latency: got %0d expected 3", lat); end
    n_cmp++; if (res !== {5'd26, 8'd99, MARGIN_ON ? 8'd96 : 8'd0}) begin n_err++; $display("FAIL rm_result: got %h expected %h", res, {5'd26, 8'd99, MARGIN_ON ? 8'd96 : 8'd0}); end
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_tie();
    test_signed();
    test_backpressure();
    test_throughput();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
